// File: rtl/iterative_mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Multiplies use a radix-2 shift-add loop and divides use a restoring loop.
// Both share one pair of WIDTH-bit working registers (acc_hi/acc_lo) and
// one operand register.
//
// Handshake: start is a request that is sampled only in IDLE. An arithmetic
// op is accepted on the edge where state==IDLE and start==1. busy stays high
// until the FIN cycle has completed. done then pulses for one cycle, and
// hi/lo hold the new result in that same cycle. There is no back-pressure:
// a start that arrives while busy is dropped.
module iterative_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Decoded request fields
  logic dec_mul, dec_div, dec_signed, dec_acc, dec_sub, dec_mthi, dec_mtlo;
  logic accept, move_hi, move_lo;
  logic neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;

  // Latched operation context
  logic             div_q, macc_q, sub_q, neg_res_q, neg_rem_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd_q, acc_hi, acc_lo;

  // Iteration and finish datapath
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_fits;
  logic [2*WIDTH-1:0] prod_raw, prod_sgn, hilo_cur, mul_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  // Decode the op code into operation class flags
  always_comb begin
    dec_mul    = 1'b0;
    dec_div    = 1'b0;
    dec_signed = 1'b0;
    dec_acc    = 1'b0;
    dec_sub    = 1'b0;
    dec_mthi   = 1'b0;
    dec_mtlo   = 1'b0;
    case (op)
      OP_MULT:  begin dec_mul = 1'b1; dec_signed = 1'b1; end
      OP_MULTU: dec_mul = 1'b1;
      OP_DIV:   begin dec_div = 1'b1; dec_signed = 1'b1; end
      OP_DIVU:  dec_div = 1'b1;
      OP_MTHI:  dec_mthi = 1'b1;
      OP_MTLO:  dec_mtlo = 1'b1;
      OP_MADD:  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_acc = 1'b1; end
      OP_MADDU: begin dec_mul = 1'b1; dec_acc = 1'b1; end
      OP_MSUB:  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
      OP_MSUBU: begin dec_mul = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
      default:  ;
    endcase
  end

  assign accept  = (state == ST_IDLE) && start && (dec_mul || dec_div);
  assign move_hi = (state == ST_IDLE) && start && dec_mthi;
  assign move_lo = (state == ST_IDLE) && start && dec_mtlo;

  // Signed ops run on magnitudes. The signs are re-applied in FIN.
  assign neg1 = dec_signed & d1[WIDTH-1];
  assign neg2 = dec_signed & d2[WIDTH-1];
  assign mag1 = neg1 ? -d1 : d1;
  assign mag2 = neg2 ? -d2 : d2;

  // Shift-add step: add the multiplicand when the multiplier LSB is set,
  // then shift the whole {acc_hi,acc_lo} right by one.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);

  // Restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. The remainder stays below the
  // divisor, so the difference fits in WIDTH bits whenever it is kept.
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_fits = (div_sh >= {1'b0, opnd_q});
  assign div_diff = div_sh[WIDTH-1:0] - opnd_q;

  // Finish: sign correction and multiply-accumulate against the current HI/LO.
  assign prod_raw = {acc_hi, acc_lo};
  assign prod_sgn = neg_res_q ? -prod_raw : prod_raw;
  assign hilo_cur = {hi, lo};
  assign mul_res  = !macc_q ? prod_sgn :
                    (sub_q ? (hilo_cur - prod_sgn) : (hilo_cur + prod_sgn));

  // With a zero divisor every trial subtract "fits". The remainder register
  // therefore ends up holding |d1|, and re-signing it gives back d1 exactly.
  // Only the quotient needs overriding.
  assign quo_res = (opnd_q == '0) ? '1 : (neg_res_q ? -acc_lo : acc_lo);
  assign rem_res = neg_rem_q ? -acc_hi : acc_hi;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. The counter value 1 means this edge performs the last iteration.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_CALC;
      ST_CALC: begin
        if (abort)                   state_nxt = ST_IDLE;
        else if (cnt == CNT_W'(1))   state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operation context load and per-cycle iteration of the working registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      div_q     <= 1'b0;
      macc_q    <= 1'b0;
      sub_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt       <= CNT_W'(WIDTH);
            div_q     <= dec_div;
            macc_q    <= dec_acc;
            sub_q     <= dec_sub;
            neg_res_q <= neg1 ^ neg2;
            neg_rem_q <= neg1;
            acc_hi    <= '0;
            if (dec_div) begin
              opnd_q <= mag2;
              acc_lo <= mag1;
            end else begin
              opnd_q <= mag1;
              acc_lo <= mag2;
            end
          end
        end
        ST_CALC: begin
          if (!abort) begin
            cnt <= cnt - 1'b1;
            if (div_q) begin
              acc_hi <= div_fits ? div_diff : div_sh[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_fits};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: busy tracks the next state, HI/LO take the FIN result or a move
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      done <= (state == ST_FIN) && !abort;
      if ((state == ST_FIN) && !abort) begin
        if (div_q) begin
          hi <= rem_res;
          lo <= quo_res;
        end else begin
          hi <= mul_res[2*WIDTH-1:WIDTH];
          lo <= mul_res[WIDTH-1:0];
        end
      end else if (move_hi) begin
        hi <= d1;
      end else if (move_lo) begin
        lo <= d1;
      end
    end
  end

endmodule

// File: tb/tb_iterative_mdu.sv
// Self-checking bench for iterative_mdu. It covers a 32-bit instance and an 8-bit instance.
module tb_iterative_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [3:0]  op;
  logic [31:0] d1, d2;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8;
  logic [3:0]  op8;
  logic [7:0]  d1_8, d2_8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic [63:0] m_hilo = '0;
  logic [63:0] exp_q[$];

  iterative_mdu #(.WIDTH(32), .CNT_W(6)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .abort(abort),
    .d1(d1), .d2(d2), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  iterative_mdu #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .abort(abort),
    .d1(d1_8), .d2(d2_8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the architectural result of one op on {hi,lo}
  function automatic logic [63:0] model_op(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] cur);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, sp, up, q64, r64, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sp = sa * sb;
    up = ua * ub;
    res = cur;
    case (o)
      4'd0: res = sp;
      4'd1: res = up;
      4'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb; sr = sa % sb;
          q64 = sq; r64 = sr;
          res = {r64[31:0], q64[31:0]};
        end
      end
      4'd3: res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      4'd4: res = {a, cur[31:0]};
      4'd5: res = {cur[63:32], a};
      4'd6: res = cur + sp;
      4'd7: res = cur + up;
      4'd8: res = cur - sp;
      4'd9: res = cur - up;
      default: res = cur;
    endcase
    return res;
  endfunction

  // Driver: present a request for one cycle
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; d1 = a; d2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  // Wait (bounded) for done. Returns the edges elapsed since the accept and the busy-high samples seen.
  task automatic wait_done(output int lat, output int bc);
    bc = 0;
    while (done !== 1'b1 && (cyc - acc_cyc) < 100) begin
      if (busy === 1'b1) bc++;
      tick();
    end
    lat = cyc - acc_cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; op = '0; d1 = '0; d2 = '0;
    start8 = 1'b0; op8 = '0; d1_8 = '0; d2_8 = '0;
    #2 rst = 1'b0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_checks++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo got %h exp 0", {hi, lo}); else n_pass++;
    n_checks++; if ({busy8, done8, hi8, lo8} !== 18'd0) $display("FAIL reset_w8 got %h exp 0", {busy8, done8, hi8, lo8}); else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    int lat, bc;
    logic [63:0] e;
    issue(4'd4, 32'h1234_5678, 32'd0);
    issue(4'd5, 32'h9ABC_DEF0, 32'd0);
    issue(4'd2, 32'd100, 32'd7);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL async_rst_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL async_rst_done got %b exp 0", done); else n_pass++;
    n_checks++; if (hi !== 32'd0) $display("FAIL async_rst_hi got %h exp 0", hi); else n_pass++;
    n_checks++; if (lo !== 32'd0) $display("FAIL async_rst_lo got %h exp 0", lo); else n_pass++;
    tick();
    rst = 1'b1;
    m_hilo = '0;
    tick();
    exp_q.push_back(model_op(4'd1, 32'd6, 32'd7, m_hilo));
    issue(4'd1, 32'd6, 32'd7);
    wait_done(lat, bc);
    e = exp_q.pop_front();
    n_checks++; if (done !== 1'b1) $display("FAIL post_rst_done got %b exp 1 lat %0d", done, lat); else n_pass++;
    n_checks++; if ({hi, lo} !== e) $display("FAIL post_rst_hilo got %h exp %h", {hi, lo}, e); else n_pass++;
    m_hilo = e;
  endtask

  task automatic test_mult_timing();
    int lat, bc;
    logic [63:0] e;
    exp_q.push_back(model_op(4'd0, 32'hFFFF_FFFE, 32'd3, m_hilo));
    issue(4'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done(lat, bc);
    e = exp_q.pop_front();
    n_checks++; if (bc !== 33) $display("FAIL mult_busy_cycles got %0d exp 33", bc); else n_pass++;
    n_checks++; if (lat !== 33 || done !== 1'b1) $display("FAIL mult_done got done=%b lat=%0d exp done=1 lat=33", done, lat); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mult_busy_at_done got %b exp 0", busy); else n_pass++;
    n_checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h exp ffffffff", hi); else n_pass++;
    n_checks++; if (lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo got %h exp fffffffa", lo); else n_pass++;
    m_hilo = e;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL done_one_pulse got %b exp 0", done); else n_pass++;
  endtask

  task automatic test_madd_msub();
    int lat, bc;
    logic [63:0] e;
    issue(4'd4, 32'd0, 32'd0);
    issue(4'd5, 32'd10, 32'd0);
    m_hilo = 64'd10;
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL move_no_busy got %b exp 00", {busy, done}); else n_pass++;
    n_checks++; if ({hi, lo} !== m_hilo) $display("FAIL move_hilo got %h exp %h", {hi, lo}, m_hilo); else n_pass++;
    exp_q.push_back(model_op(4'd7, 32'hFFFF_FFFF, 32'd2, m_hilo));
    issue(4'd7, 32'hFFFF_FFFF, 32'd2);
    wait_done(lat, bc);
    e = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== e || done !== 1'b1) $display("FAIL maddu got %h done %b exp %h", {hi, lo}, done, e); else n_pass++;
    m_hilo = e;
    exp_q.push_back(model_op(4'd8, 32'd1, 32'd9, m_hilo));
    issue(4'd8, 32'd1, 32'd9);
    wait_done(lat, bc);
    e = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== e || done !== 1'b1) $display("FAIL msub got %h done %b exp %h", {hi, lo}, done, e); else n_pass++;
    m_hilo = e;
  endtask

  task automatic test_div_cases();
    logic [3:0]  t_op[5] = '{4'd2, 4'd3, 4'd2, 4'd2, 4'd3};
    logic [31:0] t_a[5]  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [31:0] t_b[5]  = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1};
    int lat, bc;
    logic [63:0] e;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(model_op(t_op[i], t_a[i], t_b[i], m_hilo));
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(lat, bc);
      e = exp_q.pop_front();
      n_checks++; if (lat !== 33 || done !== 1'b1) $display("FAIL div%0d_latency got lat=%0d done=%b exp 33/1", i, lat, done); else n_pass++;
      n_checks++; if (lo !== e[31:0]) $display("FAIL div%0d_lo got %h exp %h", i, lo, e[31:0]); else n_pass++;
      n_checks++; if (hi !== e[63:32]) $display("FAIL div%0d_hi got %h exp %h", i, hi, e[63:32]); else n_pass++;
      m_hilo = e;
    end
  endtask

  task automatic test_busy_ignore_back_to_back();
    int lat, bc, done_cyc;
    logic [63:0] e;
    exp_q.push_back(model_op(4'd1, 32'h0001_0003, 32'h0000_0105, m_hilo));
    issue(4'd1, 32'h0001_0003, 32'h0000_0105);
    repeat (4) tick();
    op = 4'd1; d1 = 32'hFFFF_0000; d2 = 32'h7777_7777; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op = 4'd4; d1 = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bc);
    e = exp_q.pop_front();
    n_checks++; if (lat !== 33 || done !== 1'b1) $display("FAIL ignore_latency got lat=%0d done=%b exp 33/1", lat, done); else n_pass++;
    n_checks++; if ({hi, lo} !== e) $display("FAIL ignore_result got %h exp %h", {hi, lo}, e); else n_pass++;
    m_hilo = e;
    done_cyc = cyc;
    exp_q.push_back(model_op(4'd6, 32'hFFFF_FFF0, 32'd5, m_hilo));
    issue(4'd6, 32'hFFFF_FFF0, 32'd5);
    n_checks++; if ({hi, lo} !== m_hilo) $display("FAIL b2b_hold got %h exp %h", {hi, lo}, m_hilo); else n_pass++;
    wait_done(lat, bc);
    e = exp_q.pop_front();
    n_checks++; if ((cyc - done_cyc) !== 34 || done !== 1'b1) $display("FAIL b2b_spacing got %0d done=%b exp 34/1", cyc - done_cyc, done); else n_pass++;
    n_checks++; if ({hi, lo} !== e) $display("FAIL b2b_result got %h exp %h", {hi, lo}, e); else n_pass++;
    m_hilo = e;
  endtask

  task automatic test_abort();
    int lat, bc, seen;
    logic [63:0] e;
    issue(4'd3, 32'd1000, 32'd7);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else n_pass++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) $display("FAIL abort_no_done got %0d pulses exp 0", seen); else n_pass++;
    n_checks++; if ({hi, lo} !== m_hilo) $display("FAIL abort_hilo got %h exp %h", {hi, lo}, m_hilo); else n_pass++;
    abort = 1'b1;
    exp_q.push_back(model_op(4'd1, 32'd12345, 32'd678, m_hilo));
    issue(4'd1, 32'd12345, 32'd678);
    abort = 1'b0;
    wait_done(lat, bc);
    e = exp_q.pop_front();
    n_checks++; if (lat !== 33 || {hi, lo} !== e) $display("FAIL abort_start_same_cycle got lat=%0d %h exp 33 %h", lat, {hi, lo}, e); else n_pass++;
    m_hilo = e;
  endtask

  task automatic test_random();
    int lat, bc, kind;
    logic [3:0]  o;
    logic [31:0] a, b;
    logic [63:0] e;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      kind = $urandom_range(0, 7);
      if (kind == 0) b = 32'd0;
      else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (kind == 2) b = 32'($urandom_range(1, 20));
      e = model_op(o, a, b, m_hilo);
      if (o <= 4'd3 || (o >= 4'd6 && o <= 4'd9)) begin
        exp_q.push_back(e);
        issue(o, a, b);
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_checks++; if (bc !== 33 || done !== 1'b1) $display("FAIL rnd%0d_timing op %0d busy=%0d done=%b exp 33/1", i, o, bc, done); else n_pass++;
        n_checks++; if ({hi, lo} !== e) $display("FAIL rnd%0d_result op %0d a %h b %h got %h exp %h", i, o, a, b, {hi, lo}, e); else n_pass++;
      end else begin
        issue(o, a, b);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== e) $display("FAIL rnd%0d_nonarith op %0d got busy=%b done=%b %h exp 0/0 %h", i, o, busy, done, {hi, lo}, e); else n_pass++;
      end
      m_hilo = e;
    end
  endtask

  task automatic test_width8();
    logic [3:0]  t_op[6] = '{4'd1, 4'd1, 4'd3, 4'd3, 4'd1, 4'd3};
    logic [7:0]  a, b;
    logic [15:0] e16;
    int bc;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      b = (i == 0) ? 8'hFF : ((i == 3) ? 8'd0 : 8'($urandom_range(1, 255)));
      if (t_op[i] == 4'd1) e16 = {8'd0, a} * {8'd0, b};
      else if (b == 8'd0) e16 = {a, 8'hFF};
      else e16 = {a % b, a / b};
      op8 = t_op[i]; d1_8 = a; d2_8 = b; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      bc = 0;
      while (done8 !== 1'b1 && bc < 50) begin
        if (busy8 === 1'b1) bc++; else bc = 99;
        tick();
      end
      n_checks++; if (bc !== 9 || done8 !== 1'b1) $display("FAIL w8_%0d_timing got busy=%0d done=%b exp 9/1", i, bc, done8); else n_pass++;
      n_checks++; if ({hi8, lo8} !== e16) $display("FAIL w8_%0d_result op %0d a %h b %h got %h exp %h", i, t_op[i], a, b, {hi8, lo8}, e16); else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_mult_timing();
    test_madd_msub();
    test_div_cases();
    test_busy_ignore_back_to_back();
    test_abort();
    test_random();
    test_width8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
